// File: rtl/cvxif_accel_unit.sv
// CV-X-IF custom-0 coprocessor: issue buffer with commit/kill tracking and an in-order 2-stage execute.
// Optional feature macro CVXIF_ACCEL_MAC_EN adds MAC/ACCRD with a shared accumulator; default is ABSD only.
module cvxif_accel_unit #(
  parameter int unsigned XLEN    = 64,
  parameter int unsigned IdWidth = 3,
  parameter int unsigned Depth   = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               issue_valid_i,
  output logic               issue_ready_o,
  input  logic [31:0]        issue_instr_i,
  input  logic [IdWidth-1:0] issue_id_i,
  input  logic [XLEN-1:0]    issue_hartid_i,
  input  logic [XLEN-1:0]    issue_rs1_i,
  input  logic [XLEN-1:0]    issue_rs2_i,
  output logic               issue_accept_o,
  output logic               issue_writeback_o,
  input  logic               commit_valid_i,
  input  logic [IdWidth-1:0] commit_id_i,
  input  logic               commit_kill_i,
  output logic               result_valid_o,
  input  logic               result_ready_i,
  output logic [IdWidth-1:0] result_id_o,
  output logic [XLEN-1:0]    result_hartid_o,
  output logic [4:0]         result_rd_o,
  output logic [XLEN-1:0]    result_data_o,
  output logic               result_we_o
);
  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [6:0] OPC_CUSTOM0 = 7'b0001011;
  localparam logic [2:0] F3_ABSD     = 3'b010;
`ifdef CVXIF_ACCEL_MAC_EN
  localparam logic [2:0] F3_MAC      = 3'b000;
  localparam logic [2:0] F3_ACCRD    = 3'b001;
`endif

  typedef enum logic [1:0] {ST_FREE, ST_PEND, ST_COMM, ST_KILL} ent_st_e;

  typedef struct packed {
    logic [IdWidth-1:0] id;
    logic [XLEN-1:0]    hartid;
    logic [4:0]         rd;
    logic [2:0]         funct3;
    logic [XLEN-1:0]    rs1;
    logic [XLEN-1:0]    rs2;
  } ent_t;

  // ---------------- decode ----------------
  logic [2:0] dec_f3;
  logic       dec_ok;
  logic       unused_instr;

  assign dec_f3       = issue_instr_i[14:12];
  assign unused_instr = ^issue_instr_i[24:15];

  always_comb begin
    dec_ok = 1'b0;
    if (issue_instr_i[6:0] == OPC_CUSTOM0 && issue_instr_i[31:25] == 7'd0) begin
`ifdef CVXIF_ACCEL_MAC_EN
      dec_ok = (dec_f3 == F3_MAC) || (dec_f3 == F3_ACCRD) || (dec_f3 == F3_ABSD);
`else
      dec_ok = (dec_f3 == F3_ABSD);
`endif
    end
  end

  assign issue_accept_o    = dec_ok;
  assign issue_writeback_o = dec_ok;

  // ---------------- issue buffer ----------------
  ent_st_e         st_q  [Depth];
  ent_t            ent_q [Depth];
  logic [PtrW-1:0] head_q, tail_q;
  logic [CntW-1:0] cnt_q;
  ent_t            ent_in;
  ent_st_e         head_st;
  ent_t            head_ent;
  logic            push, pop;

  logic            s1_vld_q, s2_vld_q;
  logic            s2_adv, s1_fire, s1_free, s1_load;

  always_comb begin
    ent_in        = '0;
    ent_in.id     = issue_id_i;
    ent_in.hartid = issue_hartid_i;
    ent_in.rd     = issue_instr_i[11:7];
    ent_in.funct3 = dec_f3;
    ent_in.rs1    = issue_rs1_i;
    ent_in.rs2    = issue_rs2_i;
  end

  // Readiness looks only at the registered count, so a same-cycle pop does not reopen the buffer.
  assign issue_ready_o = (cnt_q < CntW'(Depth));
  assign push          = issue_valid_i && issue_ready_o && dec_ok;
  assign head_st       = st_q[head_q];
  assign head_ent      = ent_q[head_q];

  assign s2_adv  = !s2_vld_q || result_ready_i;
  assign s1_fire = s1_vld_q && s2_adv;
  assign s1_free = !s1_vld_q || s2_adv;
  assign s1_load = (head_st == ST_COMM) && s1_free;
  assign pop     = s1_load || (head_st == ST_KILL);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(Depth); i++) begin
        st_q[i]  <= ST_FREE;
        ent_q[i] <= '0;
      end
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      // Only PENDING entries match, so a commit racing the issue of its id finds nothing.
      if (commit_valid_i) begin
        for (int i = 0; i < int'(Depth); i++) begin
          if (st_q[i] == ST_PEND && ent_q[i].id == commit_id_i)
            st_q[i] <= commit_kill_i ? ST_KILL : ST_COMM;
        end
      end
      if (pop) begin
        st_q[head_q] <= ST_FREE;
        head_q       <= head_q + PtrW'(1);
      end
      if (push) begin
        st_q[tail_q]  <= ST_PEND;
        ent_q[tail_q] <= ent_in;
        tail_q        <= tail_q + PtrW'(1);
      end
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CntW'(1);
        2'b01:   cnt_q <= cnt_q - CntW'(1);
        default: ;
      endcase
    end
  end

  // ---------------- stage 1 ----------------
  ent_t s1_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_vld_q <= 1'b0;
      s1_q     <= '0;
    end else if (s1_load) begin
      s1_vld_q <= 1'b1;
      s1_q     <= head_ent;
    end else if (s1_fire) begin
      s1_vld_q <= 1'b0;
    end
  end

  logic [XLEN-1:0] absd, res_d;
  assign absd = (s1_q.rs1 >= s1_q.rs2) ? (s1_q.rs1 - s1_q.rs2) : (s1_q.rs2 - s1_q.rs1);

`ifdef CVXIF_ACCEL_MAC_EN
  logic [XLEN-1:0] s1_prod_q, acc_q, acc_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)      s1_prod_q <= '0;
    else if (s1_load) s1_prod_q <= head_ent.rs1 * head_ent.rs2;
  end

  // The op sees acc as of the stage1->stage2 move; acc updates on that same edge.
  always_comb begin
    acc_d = acc_q;
    res_d = absd;
    case (s1_q.funct3)
      F3_MAC: begin
        acc_d = acc_q + s1_prod_q;
        res_d = acc_q + s1_prod_q;
      end
      F3_ACCRD: begin
        acc_d = '0;
        res_d = acc_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)      acc_q <= '0;
    else if (s1_fire) acc_q <= acc_d;
  end
`else
  logic unused_f3;
  assign res_d     = absd;
  assign unused_f3 = ^s1_q.funct3;
`endif

  // ---------------- stage 2 / result ----------------
  logic [IdWidth-1:0] s2_id_q;
  logic [XLEN-1:0]    s2_hart_q, s2_data_q;
  logic [4:0]         s2_rd_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s2_vld_q  <= 1'b0;
      s2_id_q   <= '0;
      s2_hart_q <= '0;
      s2_rd_q   <= '0;
      s2_data_q <= '0;
    end else if (s1_fire) begin
      s2_vld_q  <= 1'b1;
      s2_id_q   <= s1_q.id;
      s2_hart_q <= s1_q.hartid;
      s2_rd_q   <= s1_q.rd;
      s2_data_q <= res_d;
    end else if (result_ready_i) begin
      s2_vld_q  <= 1'b0;
    end
  end

  assign result_valid_o  = s2_vld_q;
  assign result_we_o     = s2_vld_q;
  assign result_id_o     = s2_id_q;
  assign result_hartid_o = s2_hart_q;
  assign result_rd_o     = s2_rd_q;
  assign result_data_o   = s2_data_q;

endmodule

// File: tb/tb_cvxif_accel_unit.sv
// Bench for cvxif_accel_unit: ordered-result model with commit/kill, directed cases plus random rounds.
`timescale 1ns/1ps
module tb_cvxif_accel_unit;
`ifdef CVXIF_ACCEL_MAC_EN
  localparam bit MAC_EN = 1'b1;
`else
  localparam bit MAC_EN = 1'b0;
`endif
  localparam logic [6:0] OPC = 7'b0001011;

  logic        clk_i = 1'b0, rst_ni = 1'b0;
  logic        issue_valid_i = 1'b0, issue_ready_o;
  logic [31:0] issue_instr_i = '0;
  logic [2:0]  issue_id_i = '0;
  logic [63:0] issue_hartid_i = '0, issue_rs1_i = '0, issue_rs2_i = '0;
  logic        issue_accept_o, issue_writeback_o;
  logic        commit_valid_i = 1'b0, commit_kill_i = 1'b0;
  logic [2:0]  commit_id_i = '0;
  logic        result_valid_o, result_ready_i = 1'b1, result_we_o;
  logic [2:0]  result_id_o;
  logic [63:0] result_hartid_o, result_data_o;
  logic [4:0]  result_rd_o;

  cvxif_accel_unit #(.XLEN(64), .IdWidth(3), .Depth(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o), .issue_instr_i(issue_instr_i),
    .issue_id_i(issue_id_i), .issue_hartid_i(issue_hartid_i), .issue_rs1_i(issue_rs1_i),
    .issue_rs2_i(issue_rs2_i), .issue_accept_o(issue_accept_o), .issue_writeback_o(issue_writeback_o),
    .commit_valid_i(commit_valid_i), .commit_id_i(commit_id_i), .commit_kill_i(commit_kill_i),
    .result_valid_o(result_valid_o), .result_ready_i(result_ready_i), .result_id_o(result_id_o),
    .result_hartid_o(result_hartid_o), .result_rd_o(result_rd_o), .result_data_o(result_data_o),
    .result_we_o(result_we_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0, bad = 0, cyc = 0, rr_mode = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct { logic [2:0] id; logic [63:0] hart; logic [4:0] rd; logic [2:0] f3; logic [63:0] a, b; int st; } ment_t;
  typedef struct { logic [2:0] id; logic [63:0] hart; logic [4:0] rd; logic [63:0] data; } res_t;
  ment_t mq[$];
  res_t  exp_q[$];
  res_t  got_q[$];
  logic [63:0] macc = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk(input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] f7, input logic [6:0] opc);
    return {f7, 5'd2, 5'd1, f3, rd, opc};
  endfunction

  function automatic bit ref_acc(input logic [31:0] ins);
    if (ins[6:0] != OPC || ins[31:25] != 7'd0) return 1'b0;
    case (ins[14:12])
      3'b010:         return 1'b1;
      3'b000, 3'b001: return MAC_EN;
      default:        return 1'b0;
    endcase
  endfunction

  function automatic logic [63:0] rnd64();
    if ($urandom_range(0, 3) == 0) return 64'($urandom_range(0, 3));
    return {$urandom, $urandom};
  endfunction

  // Reference: program-order list of accepted ops; resolved head entries turn into expected results.
  initial begin
    ment_t e;
    logic [63:0] d;
    forever begin
      @(posedge clk_i or negedge rst_ni);
      if (!rst_ni) begin
        mq.delete(); exp_q.delete(); macc = '0;
      end else begin
        if (commit_valid_i)
          foreach (mq[i]) if (mq[i].st == 0 && mq[i].id == commit_id_i) mq[i].st = commit_kill_i ? 2 : 1;
        if (issue_valid_i && issue_ready_o && ref_acc(issue_instr_i)) begin
          e.id = issue_id_i; e.hart = issue_hartid_i; e.rd = issue_instr_i[11:7];
          e.f3 = issue_instr_i[14:12]; e.a = issue_rs1_i; e.b = issue_rs2_i; e.st = 0;
          mq.push_back(e);
        end
        while (mq.size() > 0 && mq[0].st != 0) begin
          e = mq.pop_front();
          if (e.st == 1) begin
            case (e.f3)
              3'b000:  begin macc = macc + e.a * e.b; d = macc; end
              3'b001:  begin d = macc; macc = '0; end
              default: d = (e.a > e.b) ? e.a - e.b : e.b - e.a;
            endcase
            exp_q.push_back('{e.id, e.hart, e.rd, d});
          end
        end
      end
    end
  end

  // Per-cycle checker.
  initial begin
    logic pv, pr;
    res_t cur, pres, r;
    pv = 1'b0; pr = 1'b0;
    forever begin
      @(negedge clk_i);
      if (!rst_ni) begin
        pv = 1'b0;
      end else begin
        cur = '{result_id_o, result_hartid_o, result_rd_o, result_data_o};
        chk("we_vs_valid", result_we_o, result_valid_o);
        chk("accept", issue_accept_o, ref_acc(issue_instr_i));
        chk("writeback", issue_writeback_o, ref_acc(issue_instr_i));
        if (pv && !pr) begin
          chk("stall_valid", result_valid_o, 1'b1);
          chk("stall_data", result_data_o, pres.data);
          chk("stall_id", result_id_o, pres.id);
        end
        if (result_valid_o && result_ready_i) begin
          if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL spurious_result: got id %0d data %0h expected none", result_id_o, result_data_o);
          end else begin
            r = exp_q.pop_front();
            chk("res_id", cur.id, r.id);
            chk("res_data", cur.data, r.data);
            chk("res_rd", cur.rd, r.rd);
            chk("res_hart", cur.hart, r.hart);
          end
          got_q.push_back(cur);
        end
        pv = result_valid_o; pr = result_ready_i; pres = cur;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk_i); #2;
      case (rr_mode)
        0:       result_ready_i = 1'b1;
        1:       result_ready_i = ($urandom_range(0, 3) != 0);
        default: result_ready_i = 1'b0;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk_i); #1;
    issue_valid_i = 1'b0; commit_valid_i = 1'b0;
  endtask

  task automatic iss(input logic [2:0] id, input logic [31:0] ins, input logic [63:0] a, input logic [63:0] b, input logic [63:0] hart);
    int n = 0;
    while (!issue_ready_o && n < 50) begin tick(); n++; end
    if (!issue_ready_o) begin total++; bad++; $display("FAIL issue_timeout: ready stayed %0d expected 1", issue_ready_o); end
    issue_valid_i = 1'b1; issue_instr_i = ins; issue_id_i = id;
    issue_rs1_i = a; issue_rs2_i = b; issue_hartid_i = hart;
    tick();
  endtask

  task automatic cmt(input logic [2:0] id, input logic kill);
    commit_valid_i = 1'b1; commit_id_i = id; commit_kill_i = kill;
    tick();
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() > 0 || mq.size() > 0 || result_valid_o) && n < 400) begin tick(); n++; end
    if (n >= 400) begin total++; bad++; $display("FAIL drain_timeout: %0d results still owed, expected 0", exp_q.size()); end
    repeat (3) tick();
  endtask

  task automatic rand_round();
    logic [2:0] ids [8];
    logic [2:0] pend [$];
    int n, ni, guard;
    for (int i = 0; i < 8; i++) ids[i] = 3'(i);
    for (int i = 7; i > 0; i--) begin
      int j;
      logic [2:0] t;
      j = $urandom_range(0, i); t = ids[i]; ids[i] = ids[j]; ids[j] = t;
    end
    n = $urandom_range(1, 4); ni = 0; guard = 0;
    while ((ni < n || pend.size() > 0) && guard < 300) begin
      if (pend.size() > 0 && $urandom_range(0, 1) == 1) begin
        int k;
        k = $urandom_range(0, pend.size() - 1);
        commit_valid_i = 1'b1; commit_id_i = pend[k]; commit_kill_i = ($urandom_range(0, 3) == 0);
        pend.delete(k);
      end else if ($urandom_range(0, 7) == 0) begin
        commit_valid_i = 1'b1; commit_id_i = ids[$urandom_range(n, 7)]; commit_kill_i = 1'($urandom_range(0, 1));
      end
      if (ni < n && issue_ready_o && $urandom_range(0, 1) == 1) begin
        logic [2:0] f3;
        logic [31:0] ins;
        f3 = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
        ins = mk(f3, 5'($urandom), ($urandom_range(0, 15) == 0) ? 7'd1 : 7'd0, OPC);
        issue_valid_i = 1'b1; issue_instr_i = ins; issue_id_i = ids[ni];
        issue_rs1_i = rnd64(); issue_rs2_i = rnd64(); issue_hartid_i = rnd64();
        if (ref_acc(ins)) pend.push_back(ids[ni]);
        ni++;
      end
      tick(); guard++;
    end
    if (guard >= 300) begin total++; bad++; $display("FAIL round_timeout: guard %0d expected below 300", guard); end
    drain();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time %0t exceeded limit", $time);
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int c, n;
    logic [63:0] held;
    repeat (2) @(negedge clk_i);
    chk("rst_ready", issue_ready_o, 1'b1);
    chk("rst_valid", result_valid_o, 1'b0);
    chk("rst_we", result_we_o, 1'b0);
    chk("rst_id", result_id_o, 3'd0);
    chk("rst_hart", result_hartid_o, 64'd0);
    chk("rst_rd", result_rd_o, 5'd0);
    chk("rst_data", result_data_o, 64'd0);
    @(posedge clk_i); #1 rst_ni = 1'b1;
    repeat (3) tick();
    chk("idle_ready", issue_ready_o, 1'b1);
    chk("idle_valid", result_valid_o, 1'b0);

    // MAC / ACCRD chain
    got_q.delete();
    iss(3'd1, mk(3'b000, 5'd5, 7'd0, OPC), 64'd3, 64'd5, 64'd0);
    iss(3'd2, mk(3'b000, 5'd6, 7'd0, OPC), 64'd2, 64'd7, 64'd1);
    cmt(3'd1, 1'b0);
    cmt(3'd2, 1'b0);
    iss(3'd3, mk(3'b001, 5'd7, 7'd0, OPC), 64'd0, 64'd0, 64'd0);
    cmt(3'd3, 1'b0);
    iss(3'd4, mk(3'b001, 5'd8, 7'd0, OPC), 64'd0, 64'd0, 64'd0);
    cmt(3'd4, 1'b0);
    drain();
`ifdef CVXIF_ACCEL_MAC_EN
    chk("mac_count", got_q.size(), 4);
    if (got_q.size() == 4) begin
      chk("mac_id1", got_q[0].data, 64'd15);
      chk("mac_id2", got_q[1].data, 64'd29);
      chk("accrd_id3", got_q[2].data, 64'd29);
      chk("accrd_after", got_q[3].data, 64'd0);
    end
`else
    chk("mac_rejected_count", got_q.size(), 0);
`endif

    // ABSD latency and wrap
    got_q.delete();
    iss(3'd0, mk(3'b010, 5'd9, 7'd0, OPC), 64'd10, 64'hFFFF_FFFF_FFFF_FFFF, 64'h5);
    commit_valid_i = 1'b1; commit_id_i = 3'd0; commit_kill_i = 1'b0; c = cyc;
    tick();
    n = 0;
    do begin @(negedge clk_i); n++; end while (!result_valid_o && n < 20);
    chk("absd_latency", 64'(cyc - c), 64'd3);
    chk("absd_data", result_data_o, 64'hFFFF_FFFF_FFFF_FFF5);
    chk("absd_rd", result_rd_o, 5'd9);
    chk("absd_hart", result_hartid_o, 64'h5);
    drain();

    // Fill the buffer, kill one
    got_q.delete();
    iss(3'd0, mk(3'b010, 5'd1, 7'd0, OPC), 64'd7, 64'd3, 64'd0);
    iss(3'd1, mk(MAC_EN ? 3'b000 : 3'b010, 5'd2, 7'd0, OPC), 64'd100, 64'd100, 64'd0);
    iss(3'd2, mk(3'b010, 5'd3, 7'd0, OPC), 64'd3, 64'd7, 64'd0);
    chk("fill3_ready", issue_ready_o, 1'b1);
    iss(3'd3, mk(MAC_EN ? 3'b001 : 3'b010, 5'd4, 7'd0, OPC), 64'd20, 64'd5, 64'd0);
    chk("full_ready", issue_ready_o, 1'b0);
    cmt(3'd1, 1'b1);
    cmt(3'd0, 1'b0);
    cmt(3'd2, 1'b0);
    cmt(3'd3, 1'b0);
    drain();
    chk("kill_count", got_q.size(), 3);
    if (got_q.size() == 3) begin
      chk("kill_ord0", got_q[0].id, 3'd0);
      chk("kill_ord1", got_q[1].id, 3'd2);
      chk("kill_ord2", got_q[2].id, 3'd3);
      chk("kill_data0", got_q[0].data, 64'd4);
      chk("kill_data1", got_q[1].data, 64'd4);
`ifdef CVXIF_ACCEL_MAC_EN
      chk("kill_acc_untouched", got_q[2].data, 64'd0);
`else
      chk("kill_data2", got_q[2].data, 64'd15);
`endif
    end

    // Backpressure
    got_q.delete();
    rr_mode = 2;
    iss(3'd4, mk(3'b010, 5'd10, 7'd0, OPC), 64'd1, 64'd50, 64'd0);
    iss(3'd5, mk(3'b010, 5'd11, 7'd0, OPC), 64'd60, 64'd2, 64'd0);
    iss(3'd6, mk(3'b010, 5'd12, 7'd0, OPC), 64'd9, 64'd9, 64'd0);
    cmt(3'd4, 1'b0); cmt(3'd5, 1'b0); cmt(3'd6, 1'b0);
    repeat (3) tick();
    held = result_data_o;
    repeat (10) tick();
    chk("stall_valid_hi", result_valid_o, 1'b1);
    chk("stall_held", result_data_o, held);
    chk("stall_head_data", result_data_o, 64'd49);
    chk("stall_none_taken", got_q.size(), 0);
    rr_mode = 0;
    repeat (3) tick();
    chk("release_1pc", got_q.size(), 3);
    drain();
    chk("release_total", got_q.size(), 3);

    // Illegal encodings
    got_q.delete();
    issue_instr_i = mk(3'b011, 5'd1, 7'd0, OPC); #1;
    chk("f3_011_accept", issue_accept_o, 1'b0);
    chk("f3_011_wb", issue_writeback_o, 1'b0);
    issue_instr_i = mk(3'b010, 5'd1, 7'd1, OPC); #1;
    chk("f7_accept", issue_accept_o, 1'b0);
    iss(3'd7, mk(3'b011, 5'd1, 7'd0, OPC), 64'd1, 64'd2, 64'd0);
    iss(3'd6, mk(3'b010, 5'd1, 7'd1, OPC), 64'd1, 64'd2, 64'd0);
    iss(3'd5, mk(3'b010, 5'd1, 7'd0, 7'b0101011), 64'd1, 64'd2, 64'd0);
    cmt(3'd7, 1'b0); cmt(3'd6, 1'b0); cmt(3'd5, 1'b0);
    repeat (8) tick();
    chk("illegal_no_result", got_q.size(), 0);
    chk("illegal_ready", issue_ready_o, 1'b1);

    // Reset mid-flight
    got_q.delete();
    iss(3'd1, mk(3'b010, 5'd1, 7'd0, OPC), 64'd9, 64'd4, 64'd0);
    iss(3'd2, mk(3'b000, 5'd2, 7'd0, OPC), 64'd3, 64'd5, 64'd0);
    cmt(3'd1, 1'b0);
    cmt(3'd2, 1'b0);
    rst_ni = 1'b0;
    @(negedge clk_i);
    chk("midrst_valid", result_valid_o, 1'b0);
    chk("midrst_ready", issue_ready_o, 1'b1);
    tick(); rst_ni = 1'b1;
    repeat (10) tick();
    chk("midrst_no_result", got_q.size(), 0);
    iss(3'd3, mk(MAC_EN ? 3'b001 : 3'b010, 5'd3, 7'd0, OPC), 64'd2, 64'd8, 64'd0);
    cmt(3'd3, 1'b0);
    drain();
    chk("midrst_after_count", got_q.size(), 1);
    if (got_q.size() == 1) chk("midrst_after_data", got_q[0].data, MAC_EN ? 64'd0 : 64'd6);

    // Random rounds
    rr_mode = 1;
    for (int r = 0; r < 60; r++) rand_round();
    rr_mode = 0;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
